// File: rtl/fec_pkg.sv
// Shared constants and state encoding for the 802.16 rate-1/2 K=7 tail-biting
// convolutional encoder; the step function is reused by the decoder reference model.
package fec_pkg;

  localparam int K = 7;
  // Bit 6 taps the current input, bit 0 taps the oldest state bit s6.
  localparam logic [K-1:0] G1 = 7'o171;
  localparam logic [K-1:0] G2 = 7'o133;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    PRIME   = 2'd1,
    ENCODE  = 2'd2
  } fec_state_e;

endpackage

// File: rtl/cc_enc_step.sv
// One combinational step of the K=7 convolutional code: pair for input u from
// state s (s[1] most recent), plus the state after shifting u in.
module cc_enc_step
  import fec_pkg::*;
(
  input  logic       u_i,
  input  logic [6:1] s_i,
  output logic [1:0] xy_o,
  output logic [6:1] s_nxt_o
);

  logic [K-1:0] taps;

  assign taps    = {u_i, s_i[1], s_i[2], s_i[3], s_i[4], s_i[5], s_i[6]};
  assign xy_o    = {^(taps & G1), ^(taps & G2)};
  assign s_nxt_o = {s_i[5:1], u_i};

endmodule

// File: rtl/cc_tailbite_encoder.sv
// Buffers one FEC block, primes the encoder with the last six bits of the block
// (tail-biting) and streams one {X,Y} pair per output handshake.
module cc_tailbite_encoder
  import fec_pkg::*;
#(
  parameter  int BLOCK_LEN = 96,
  localparam int CNT_W     = $clog2(BLOCK_LEN)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_bit,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [1:0] out_xy,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last
);

  fec_state_e           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BLOCK_LEN-1:0] buf_q, buf_d;
  logic [6:1]           s_q, s_d;
  logic [1:0]           xy_q, xy_d;
  logic                 vld_q, vld_d;
  logic                 last_q, last_d;

  logic                 cnt_last;
  logic [CNT_W-1:0]     nidx;
  logic [6:1]           s_init;
  logic                 step_u;
  logic [6:1]           step_s;
  logic [1:0]           step_xy;
  logic [6:1]           step_ns;

  assign cnt_last = (cnt_q == CNT_W'(BLOCK_LEN - 1));

  always_comb begin
    s_init = '0;
    for (int k = 1; k <= 6; k++) s_init[k] = buf_q[BLOCK_LEN-k];
  end

  // s_q holds the state after the bit of the pair currently on out_xy, so the
  // next pair is a single step away and one encoder instance suffices.
  assign nidx   = (state_q == ENCODE && !cnt_last) ? cnt_q + 1'b1 : '0;
  assign step_u = buf_q[nidx];
  assign step_s = (state_q == PRIME) ? s_init : s_q;

  cc_enc_step u_step (
    .u_i     (step_u),
    .s_i     (step_s),
    .xy_o    (step_xy),
    .s_nxt_o (step_ns)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    s_d     = s_q;
    xy_d    = xy_q;
    vld_d   = vld_q;
    last_d  = last_q;
    case (state_q)
      COLLECT: begin
        if (in_valid) begin
          buf_d[cnt_q] = in_bit;
          if (cnt_last) begin
            cnt_d   = '0;
            state_d = PRIME;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      PRIME: begin
        xy_d    = step_xy;
        s_d     = step_ns;
        vld_d   = 1'b1;
        last_d  = 1'b0;
        state_d = ENCODE;
      end
      ENCODE: begin
        if (out_ready) begin
          if (cnt_last) begin
            vld_d   = 1'b0;
            last_d  = 1'b0;
            cnt_d   = '0;
            state_d = COLLECT;
          end else begin
            cnt_d  = cnt_q + 1'b1;
            xy_d   = step_xy;
            s_d    = step_ns;
            last_d = (cnt_q == CNT_W'(BLOCK_LEN - 2));
          end
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= COLLECT;
      cnt_q   <= '0;
      buf_q   <= '0;
      s_q     <= '0;
      xy_q    <= '0;
      vld_q   <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
      s_q     <= s_d;
      xy_q    <= xy_d;
      vld_q   <= vld_d;
      last_q  <= last_d;
    end
  end

  assign in_ready  = (state_q == COLLECT);
  assign out_xy    = xy_q;
  assign out_valid = vld_q;
  assign out_last  = last_q;

endmodule

// File: tb/tb_cc_tailbite_encoder.sv
// Directed bench for the tail-biting encoder: hand-computed pair tables for
// fixed blocks, an equation-level model for the random block.
module tb_cc_tailbite_encoder;

  localparam int N = 96;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_bit, in_valid, in_ready;
  logic [1:0] out_xy;
  logic       out_valid, out_ready, out_last;

  int n_chk = 0;
  int n_err = 0;

  logic [N-1:0] cur_u;
  logic [1:0]   exp_xy [N];

  cc_tailbite_encoder #(.BLOCK_LEN(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_bit    (in_bit),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_xy    (out_xy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [6:1] init_state(input logic [N-1:0] u);
    logic [6:1] s;
    for (int k = 1; k <= 6; k++) s[k] = u[N-k];
    return s;
  endfunction

  task automatic fill_model(input logic [N-1:0] u);
    logic [6:1] s;
    s = init_state(u);
    for (int i = 0; i < N; i++) begin
      exp_xy[i][1] = u[i] ^ s[1] ^ s[2] ^ s[3] ^ s[6];
      exp_xy[i][0] = u[i] ^ s[2] ^ s[3] ^ s[5] ^ s[6];
      s = {s[5:1], u[i]};
    end
  endtask

  task automatic fill_const(input logic [1:0] v);
    for (int i = 0; i < N; i++) exp_xy[i] = v;
  endtask

  task automatic push(input logic [N-1:0] u, input bit rnd);
    int i = 0;
    int guard = 0;
    cur_u = u;
    while (i < N && guard < 4000) begin
      @(negedge clk);
      guard++;
      in_bit   = u[i];
      in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (in_valid && in_ready) i++;
    end
    if (i < N) chk("push_timeout", i, N);
    // PRIME cycle: nothing offered yet, input closed
    @(negedge clk);
    in_valid = 1'b0;
    chk("prime_valid", out_valid, 1'b0);
    chk("prime_in_ready", in_ready, 1'b0);
  endtask

  task automatic pull(input int nmax, input bit rnd, input bit noise);
    int j = 0;
    int guard = 0;
    bit stall = 1'b0;
    logic [1:0] pxy = '0;
    logic plast = 1'b0;
    while (j < nmax && guard < 4000) begin
      @(negedge clk);
      guard++;
      if (guard == 1) chk("latency_valid", out_valid, 1'b1);
      if (stall) begin
        chk("hold_xy", out_xy, pxy);
        chk("hold_last", out_last, plast);
      end
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (noise) begin
        in_valid = 1'($urandom_range(0, 1));
        in_bit   = 1'($urandom_range(0, 1));
      end
      stall = out_valid && !out_ready;
      pxy   = out_xy;
      plast = out_last;
      if (out_valid && out_ready) begin
        chk($sformatf("pair%0d", j), out_xy, exp_xy[j]);
        chk($sformatf("last%0d", j), out_last, (j == N - 1));
        chk("enc_in_ready", in_ready, 1'b0);
        j++;
      end
    end
    if (j < nmax) chk("pull_timeout", j, nmax);
  endtask

  task automatic end_block();
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("end_valid", out_valid, 1'b0);
    chk("end_last", out_last, 1'b0);
    chk("end_in_ready", in_ready, 1'b1);
    chk("tailbite_state", dut.s_q, init_state(cur_u));
  endtask

  logic [1:0]   imp0 [7];
  logic [1:0]   imp95 [6];
  logic [N-1:0] u;

  initial begin
    imp0  = '{2'b11, 2'b10, 2'b11, 2'b11, 2'b00, 2'b01, 2'b11};
    imp95 = '{2'b10, 2'b11, 2'b11, 2'b00, 2'b01, 2'b11};
    reset = 1'b1; in_bit = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_xy", out_xy, 2'b00);
    chk("rst_last", out_last, 1'b0);
    reset = 1'b0;

    // all zeros
    fill_const(2'b00);
    push('0, 1'b0); pull(N, 1'b0, 1'b0); end_block();

    // all ones
    fill_const(2'b11);
    push('1, 1'b0); pull(N, 1'b0, 1'b0); end_block();

    // impulse at u[0]
    fill_const(2'b00);
    for (int i = 0; i < 7; i++) exp_xy[i] = imp0[i];
    u = '0; u[0] = 1'b1;
    push(u, 1'b0); pull(N, 1'b0, 1'b0); end_block();

    // impulse at u[95], exercises the wrap-around priming
    fill_const(2'b00);
    for (int i = 0; i < 6; i++) exp_xy[i] = imp95[i];
    exp_xy[N-1] = 2'b11;
    u = '0; u[N-1] = 1'b1;
    push(u, 1'b0); pull(N, 1'b0, 1'b0); end_block();

    // random block with bubbles, stalls and ignored input during encode
    u = {$urandom, $urandom, $urandom};
    fill_model(u);
    push(u, 1'b1); pull(N, 1'b1, 1'b1); end_block();

    // reset after pair 40 is handed over
    u = {$urandom, $urandom, $urandom};
    fill_model(u);
    push(u, 1'b0); pull(41, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midrst_valid", out_valid, 1'b0);
    chk("midrst_in_ready", in_ready, 1'b1);
    @(negedge clk);
    reset = 1'b0;
    fill_const(2'b11);
    push('1, 1'b0); pull(N, 1'b0, 1'b0); end_block();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
